// File: rtl/bcd_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter.
// Contents: the BCD digit type, the digit limits, and a digit validity check.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD counter.
// Ports (slave = counter side):
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   load      in   synchronous parallel load strobe
//   load_val  in   BCD value to load, digit 0 in bits [3:0]
//   count     out  registered BCD count
//   tc        out  terminal count (combinational)
//   load_err  out  registered pulse after a load with a non-BCD digit
interface bcd_updown_counter_if #(parameter int DIGITS = 2);

  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, load_err
  );

endinterface

// File: rtl/bcd_digit_stage.sv
// One BCD digit of the cascaded counter.
// Ports:
//   clk_i         system clock
//   clr_i         asynchronous active-high clear
//   cin_i         step enable from the previous stage (or the counter enable)
//   hold_i        blocks stepping (used for saturation at the top level)
//   up_dn_i       1 = increment, 0 = decrement
//   load_i        parallel load strobe
//   load_digit_i  digit to load; non-BCD values are written as 0
//   digit_o       registered digit value
//   cout_o        step enable for the next stage: cin_i and digit at terminal value
//   invalid_o     load_digit_i is not a BCD digit
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       cin_i,
  input  logic       hold_i,
  input  logic       up_dn_i,
  input  logic       load_i,
  input  bcd_digit_t load_digit_i,
  output bcd_digit_t digit_o,
  output logic       cout_o,
  output logic       invalid_o
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = is_bcd_valid(load_digit_i) ? load_digit_i : BCD_MIN;
    end else if (cin_i && !hold_i) begin
      if (up_dn_i) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else         digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end

  // Carry/borrow depends only on the incoming enable and the current digit,
  // never on hold_i, so the saturation gating cannot form a combinational loop.
  assign cout_o    = cin_i & (up_dn_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
  assign invalid_o = ~is_bcd_valid(load_digit_i);
  assign digit_o   = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with load, digit validation
// and a terminal-count output for chaining (tc of one instance drives en of
// the next; both share clk and up_dn).
// Ports:
//   clk   system clock, rising edge
//   clr   asynchronous active-high clear
//   bus   slave side of bcd_updown_counter_if (en, up_dn, load, load_val,
//         count, tc, load_err)
// Parameter DIGITS: number of cascaded digits (1..8).
// Build option: define BCD_COUNTER_SATURATE_EN to hold at all-9s (up) or
// all-0s (down) instead of wrapping; load behaviour is unaffected.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic clk,
  input  logic clr,
  bcd_updown_counter_if.slave bus
);

  logic [DIGITS:0]     carry;
  logic [DIGITS-1:0]   invalid;
  logic [4*DIGITS-1:0] count_w;
  logic                sat_hold;
  logic                load_err_q, load_err_d;

  assign carry[0] = bus.en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_stage
    bcd_digit_stage u_stage (
      .clk_i        (clk),
      .clr_i        (clr),
      .cin_i        (carry[i]),
      .hold_i       (sat_hold),
      .up_dn_i      (bus.up_dn),
      .load_i       (bus.load),
      .load_digit_i (bus.load_val[4*i +: 4]),
      .digit_o      (count_w[4*i +: 4]),
      .cout_o       (carry[i+1]),
      .invalid_o    (invalid[i])
    );
  end

`ifdef BCD_COUNTER_SATURATE_EN
  // At the terminal value with en high, freeze every digit.
  assign sat_hold = carry[DIGITS];
`else
  assign sat_hold = 1'b0;
`endif

  assign load_err_d = bus.load & (|invalid);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) load_err_q <= 1'b0;
    else     load_err_q <= load_err_d;
  end

  assign bus.count    = count_w;
  assign bus.tc       = carry[DIGITS];
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  localparam int DIGITS = 2;
  localparam int MODN   = 100;
  localparam int MAXN   = MODN - 1;

  logic clk = 1'b1;
  logic clr = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus ();
  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus_lo ();
  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus_hi ();

  bcd_updown_counter #(.DIGITS(DIGITS)) dut    (.clk(clk), .clr(clr), .bus(bus));
  bcd_updown_counter #(.DIGITS(DIGITS)) dut_lo (.clk(clk), .clr(clr), .bus(bus_lo));
  bcd_updown_counter #(.DIGITS(DIGITS)) dut_hi (.clk(clk), .clr(clr), .bus(bus_hi));

  assign bus_hi.en       = bus_lo.tc;
  assign bus_hi.up_dn    = bus_lo.up_dn;
  assign bus_hi.load     = 1'b0;
  assign bus_hi.load_val = '0;

  always #5 clk = ~clk;

  // ---------------- behavioural model (integer domain) ----------------
  int   m_n   = 0;
  logic m_err = 1'b0;
  int   c_n   = 0;   // cascade pair as one 4-digit decimal number

  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] b;
    int v;
    b = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int load_value(input logic [4*DIGITS-1:0] lv);
    int n, w, d;
    n = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      n = n + d * w;
      w = w * 10;
    end
    return n;
  endfunction

  function automatic logic load_bad(input logic [4*DIGITS-1:0] lv);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (lv[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic int step_n(input int n, input logic up);
`ifdef BCD_COUNTER_SATURATE_EN
    if (up) return (n == MAXN) ? n : n + 1;
    else    return (n == 0)    ? n : n - 1;
`else
    if (up) return (n + 1) % MODN;
    else    return (n + MODN - 1) % MODN;
`endif
  endfunction

  function automatic int cascade_step(input int n);
`ifdef BCD_COUNTER_SATURATE_EN
    if (n % 100 != 99)     return n + 1;
    else if (n / 100 != 99) return n + 100;
    else                    return n;
`else
    return (n + 1) % 10000;
`endif
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_n   <= 0;
      m_err <= 1'b0;
      c_n   <= 0;
    end else begin
      if (bus.load) begin
        m_n   <= load_value(bus.load_val);
        m_err <= load_bad(bus.load_val);
      end else begin
        m_err <= 1'b0;
        if (bus.en) m_n <= step_n(m_n, bus.up_dn);
      end
      if (bus_lo.en && bus_lo.up_dn) c_n <= cascade_step(c_n);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    check("model_count", 32'(bus.count), 32'(to_bcd(m_n)));
    check("model_tc", 32'(bus.tc),
          32'(bus.en & (bus.up_dn ? (m_n == MAXN) : (m_n == 0))));
    check("model_load_err", 32'(bus.load_err), 32'(m_err));
    check("casc_lo", 32'(bus_lo.count), 32'(to_bcd(c_n % 100)));
    check("casc_hi", 32'(bus_hi.count), 32'(to_bcd(c_n / 100)));
    check("casc_tc0", 32'(bus_lo.tc), 32'(bus_lo.en & bus_lo.up_dn & (c_n % 100 == 99)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    bus.en = 1'b1; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    bus_lo.en = 1'b0; bus_lo.up_dn = 1'b1; bus_lo.load = 1'b0; bus_lo.load_val = '0;

    #2;
    check("reset_count", 32'(bus.count), 32'h00);
    check("reset_err", 32'(bus.load_err), 32'h0);
    #13 clr = 1'b0;

    repeat (12) @(posedge clk);
    #1;
    check("count_12", 32'(bus.count), 32'h12);

    @(posedge clk);
    #3 clr = 1'b1;
    #1;
    check("clr_async", 32'(bus.count), 32'h00);
    @(negedge clk);
    #1 clr = 1'b0;

    // up wrap
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h98;
    tick();
    check("load_98", 32'(bus.count), 32'h98);
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b1;
    tick();
    check("up_99", 32'(bus.count), 32'h99);
    check("up_tc_99", 32'(bus.tc), 32'h1);
    tick();
`ifdef BCD_COUNTER_SATURATE_EN
    check("up_sat", 32'(bus.count), 32'h99);
    check("up_sat_tc", 32'(bus.tc), 32'h1);
`else
    check("up_wrap", 32'(bus.count), 32'h00);
    check("up_wrap_tc", 32'(bus.tc), 32'h0);
`endif

    // down wrap
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h01;
    tick();
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b0;
    tick();
    check("dn_00", 32'(bus.count), 32'h00);
    check("dn_tc_00", 32'(bus.tc), 32'h1);
    tick();
`ifdef BCD_COUNTER_SATURATE_EN
    check("dn_sat", 32'(bus.count), 32'h00);
    tick();
    check("dn_sat2", 32'(bus.count), 32'h00);
`else
    check("dn_wrap", 32'(bus.count), 32'h99);
    tick();
    check("dn_98", 32'(bus.count), 32'h98);
`endif

    // invalid load
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h3C;
    tick();
    check("ld_3C", 32'(bus.count), 32'h30);
    check("ld_3C_err", 32'(bus.load_err), 32'h1);
    bus.load = 1'b0;
    tick();
    check("err_pulse_end", 32'(bus.load_err), 32'h0);
    check("hold_30", 32'(bus.count), 32'h30);
    bus.load = 1'b1; bus.load_val = 8'h45;
    tick();
    check("ld_45", 32'(bus.count), 32'h45);
    check("ld_45_err", 32'(bus.load_err), 32'h0);
    bus.load_val = 8'h9A;
    tick();
    check("ld_9A", 32'(bus.count), 32'h90);
    check("ld_9A_err", 32'(bus.load_err), 32'h1);

    // priority and hold
    bus.load = 1'b1; bus.en = 1'b1; bus.up_dn = 1'b1; bus.load_val = 8'h57;
    tick();
    check("ld_beats_en", 32'(bus.count), 32'h57);
    bus.load = 1'b0; bus.en = 1'b0;
    repeat (5) tick();
    check("hold_57", 32'(bus.count), 32'h57);
    bus.en = 1'b1; bus.up_dn = 1'b1;
    tick();
    check("up_58", 32'(bus.count), 32'h58);
    bus.up_dn = 1'b0;
    tick();
    check("dn_57", 32'(bus.count), 32'h57);
    bus.en = 1'b0;

    // cascade
    bus_lo.up_dn = 1'b1; bus_lo.en = 1'b1;
    repeat (99) tick();
    check("casc_lo_99", 32'(bus_lo.count), 32'h99);
    check("casc_tc0_99", 32'(bus_lo.tc), 32'h1);
    check("casc_hi_00", 32'(bus_hi.count), 32'h00);
    tick();
    bus_lo.en = 1'b0;
    check("casc_hi_01", 32'(bus_hi.count), 32'h01);
`ifdef BCD_COUNTER_SATURATE_EN
    check("casc_lo_sat", 32'(bus_lo.count), 32'h99);
`else
    check("casc_lo_00", 32'(bus_lo.count), 32'h00);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit decade counter.
- Adds digit cascading, up/down counting, count enable, synchronous parallel load with digit validation, and a terminal-count output for chaining.
- Used as the display/event-count block in lab designs (clock dividers, stopwatch, 7-segment drivers).

Parameters:
- DIGITS, 2, number of cascaded BCD digits (1..8); count width = 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
- en  input  1  count enable; one step per clk edge while high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i], with digit 0 least significant.
- count  output  4*DIGITS  current BCD count, registered.
- tc  output  1  terminal count, combinational: en & (up_dn ? all digits == 9 : all digits == 0).
- load_err  output  1  registered one-cycle pulse: previous load carried at least one digit > 9.

Behaviour:
- Reset: while clr = 1, count = 0 and load_err = 0, asynchronously. Release is synchronous to the next clk edge.
- Priority per edge: clr > load > en > hold.
- load = 1:
  - Each digit of load_val is checked independently.
  - A digit value 10..15 is written as 0; valid digits are written unchanged.
  - load_err = 1 on the following cycle if any digit was invalid, otherwise 0.
  - en is ignored in a load cycle (load wins a simultaneous load/en).
- load = 0, en = 1, up_dn = 1:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and generates a carry into the next digit.
  - Overall count N goes to (N + 1) mod 10^DIGITS; for DIGITS = 2, 99 -> 00.
- load = 0, en = 1, up_dn = 0:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and generates a borrow into the next digit.
  - 00 -> 99 for DIGITS = 2.
- en = 0 and load = 0: count holds.
- Latency: count reflects a step or load one clk edge after the control is sampled. tc follows count and the en/up_dn inputs combinationally, with no added latency.
- Direction change is allowed on any cycle. up_dn is sampled at the same edge as en; there is no pipeline.
- load_err is 0 in every cycle not directly following a load.
- Invariant: count never holds a non-BCD digit.
- Cascading: tc of one instance drives en of the next instance. Both instances share clk and up_dn.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - Up at all-9s holds (99 stays 99).
  - Down at all-0s holds.
  - tc is still asserted in the saturated state while en = 1.
  - Load behaviour is unchanged.
- Undefined: wrap-around as described above.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (4-bit).
  - Constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - Function is_bcd_valid.
- Sub-module bcd_digit_stage, one instance per digit via generate:
  - Inputs: cin (step enable), up_dn, load, load digit.
  - Outputs: digit, cout (combinational: cin & digit at terminal value for the direction).
  - The stage chain's cout is the tc source.
- Top level handles clr fan-out, load_err aggregation, and the saturation gating.

Test Plan (DIGITS = 2):
- Reset and count: clr = 1 for 15 ns, then 0; en = 1, up_dn = 1 -> count = 00 during clr; after 12 enabled edges, count = 12; clr pulsed mid-count -> count = 00 immediately, without waiting for a clk edge.
- Up wrap: load 98 then en = 1, up_dn = 1 -> count 99 with tc = 1; next edge count = 00, tc = 0. With BCD_COUNTER_SATURATE_EN defined -> count stays 99 and tc stays 1.
- Down wrap: load 01, en = 1, up_dn = 0 -> 00 (tc = 1), then 99, then 98. With the macro defined -> holds at 00.
- Invalid load: load_val = 8'h3C -> count = 30; load_err = 1 for exactly one cycle. load_val = 8'h45 -> count = 45, load_err = 0.
- Priority and hold: load = 1 with en = 1, load_val = 8'h57 -> count = 57, no increment that cycle; en = 0 for 5 edges -> count stays 57; toggling up_dn with en = 1 gives 58 -> 57.
- Cascade: two instances with tc0 -> en1, counting up from 0000 for 100 edges -> upper instance = 01, lower = 00; in up mode, tc0 is high only in cycles where the lower count is 99.
